// File: rtl/mont_mult_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier between NREQ requesters.
// Captures operands at grant, sequences mult_resetn/start/done and aborts on a watchdog timeout.
//
// state | meaning
// IDLE  | multiplier held in reset, waiting for any request
// ISSUE | one-cycle start pulse, watchdog loaded
// BUSY  | waiting for mult_done or watchdog terminal count
// RESP  | done/err/result presented to the granted requester

module mont_mult_arbiter #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 1024,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] in_a,
  input  logic [NREQ*WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0]      in_m,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [WIDTH-1:0]      result,
  output logic                  mult_resetn,
  output logic                  mult_start,
  output logic [WIDTH-1:0]      mult_a,
  output logic [WIDTH-1:0]      mult_b,
  output logic [WIDTH-1:0]      mult_m,
  input  logic [WIDTH-1:0]      mult_result,
  input  logic                  mult_done
);

  localparam int PW = (NREQ > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [15:0] WD_LOAD = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, pick_idx, ptr_nxt;
  logic [NREQ-1:0] pick_onehot;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [15:0]     wdog;
  logic            any_req, wdog_tc;

  assign any_req = |req;
  assign wdog_tc = (wdog == 16'd0);
  assign mult_m  = in_m;

  // Walk ptr, ptr+1, ... downwards so the candidate closest to ptr is written last.
  always_comb begin : rr_pick
    logic [CW-1:0] cand;
    pick_idx = '0;
    cand     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (req[cand[PW-1:0]]) pick_idx = cand[PW-1:0];
    end
  end

  assign ptr_nxt     = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
  assign pick_onehot = NREQ'(1) << pick_idx;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == PW'(k)) begin
        sel_a = in_a[k*WIDTH +: WIDTH];
        sel_b = in_b[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_BUSY;
      S_BUSY:  if (mult_done || wdog_tc) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Multiplier is only out of reset while an operation is in flight.
  always_comb begin
    mult_resetn = 1'b0;
    mult_start  = 1'b0;
    unique case (state)
      S_ISSUE: begin
        mult_resetn = 1'b1;
        mult_start  = 1'b1;
      end
      S_BUSY:  mult_resetn = 1'b1;
      default: ;
    endcase
  end

  // Watchdog counts down from TIMEOUT-1; terminal count in BUSY is the abort point.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt    <= '0;
      done   <= '0;
      err    <= 1'b0;
      result <= '0;
      ptr    <= '0;
      mult_a <= '0;
      mult_b <= '0;
      wdog   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt    <= pick_onehot;
            mult_a <= sel_a;
            mult_b <= sel_b;
            ptr    <= ptr_nxt;
          end
        end
        S_ISSUE: wdog <= WD_LOAD;
        S_BUSY: begin
          if (mult_done) begin
            result <= mult_result;
            err    <= 1'b0;
            done   <= gnt;
          end else if (wdog_tc) begin
            err    <= 1'b1;
            done   <= gnt;
          end else begin
            wdog   <= wdog - 16'd1;
          end
        end
        S_RESP: begin
          gnt  <= '0;
          done <= '0;
          err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mont_mult_arbiter.md
Name: mont_mult_arbiter

Overview:
Shares one Montgomery multiplier instance between NREQ requesters, for example two ladder engines or a ladder plus a pre/post-processing unit. Arbitration is round-robin.
- Latches the granted requester's operands and sequences the multiplier's resetn/start/done protocol.
- Guards each operation with a watchdog timeout.
- Returns the product with a one-cycle done pulse to the granted requester.

Parameters:
NREQ, 2, number of requesters (2..4)
WIDTH, 1024, operand/result width in bits
TIMEOUT, 4096, max cycles from mult_start to mult_done before abort (must be < 2^16)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request level
in_a  in  NREQ*WIDTH  operand A, slice i = requester i
in_b  in  NREQ*WIDTH  operand B, slice i = requester i
in_m  in  WIDTH  modulus, shared, stable while any req high
gnt  out  NREQ  one-hot grant, registered
done  out  NREQ  one-cycle completion pulse, registered
err  out  1  qualifies done: 1 = timeout abort
result  out  WIDTH  last successful product, registered
mult_resetn  out  1  multiplier active-low reset
mult_start  out  1  multiplier start pulse
mult_a  out  WIDTH  latched operand A
mult_b  out  WIDTH  latched operand B
mult_m  out  WIDTH  in_m passed through
mult_result  in  WIDTH  multiplier result
mult_done  in  1  multiplier done, may be level or pulse

Behaviour:
Reset (async, resetn=0):
- state=IDLE; gnt=0, done=0, err=0, result=0.
- Round-robin pointer ptr=0; operand registers=0; watchdog=0.
- mult_resetn is decoded from state, so it is 0 immediately.
- Reset mid-operation abandons the operation; no done is issued.

FSM states: IDLE, ISSUE, BUSY, RESP.

IDLE:
- mult_resetn=0, mult_start=0.
- If any req bit is set, pick the first i with req[i]=1, searching ptr, ptr+1, ... mod NREQ.
- At that edge: gnt<=onehot(i); mult_a/mult_b<=in_a/in_b slice i; ptr<=(i+1) mod NREQ; state->ISSUE.
- No req: stay in IDLE.

ISSUE (exactly 1 cycle):
- mult_resetn=1, mult_start=1; watchdog cleared; state->BUSY.

BUSY:
- mult_resetn=1, mult_start=0; watchdog increments each cycle.
- mult_done=1: result<=mult_result, err<=0, state->RESP.
- Else if watchdog==TIMEOUT-1: result unchanged, err<=1, state->RESP.
- mult_done has priority if both occur in the same cycle.
- mult_done is ignored outside BUSY.

RESP (exactly 1 cycle):
- done = gnt (one-hot pulse); err valid; result valid and held until the next successful completion.
- mult_resetn=0; gnt<=0, done<=0, err<=0 at exit; state->IDLE.

Latency and throughput:
- Grant edge E0 to done cycle = 2 + Lm cycles, where Lm = cycles from mult_start to mult_done.
- At least 1 IDLE cycle between operations, so back-to-back requests are served at one per Lm+3 cycles.

Handshake:
- Operands are captured at grant, so the requester may change them afterwards.
- A requester must not raise req again for a new operation until it has seen its done.
- Deasserting req before grant means the request is never served.
- Deasserting req after grant does not stop the operation; done still pulses.
- Simultaneous requests are resolved by ptr only. No requester waits more than NREQ-1 operations.

Outputs:
- gnt, done, err and result come directly from registers (no combinational path from inputs).
- mult_a/mult_b are registers; mult_m = in_m.

Test Plan:
Bench uses a behavioural multiplier stub: fixed latency Lm=10, returns (a*b) mod m, done as a one-cycle pulse.
1. req=01, a0=5, b0=7, m=13 -> gnt=01 one cycle after req sampled; mult_start high exactly 1 cycle; done=01 exactly 12 cycles after grant edge; result=9; err=0; mult_resetn=0 in IDLE and RESP.
2. req=11 held from reset, a0=5,b0=7,a1=3,b1=4, m=13 -> served in order 0,1,0,1; results 9, 12, 9, 12; done pulses alternate 01/10; exactly one IDLE cycle between operations.
3. Stub never raises done, TIMEOUT=16 -> done=01 with err=1, 17 cycles after the ISSUE cycle; result keeps its previous value (9); next request is then served normally.
4. resetn driven low during BUSY -> gnt, done and mult_resetn go 0 immediately, no done pulse; after release, req=10 is granted first (ptr=0 but req0 low) and completes correctly.
5. req0 dropped 1 cycle after grant -> operation completes and done=01; no second grant to requester 0.
6. mult_done held as a level, plus a stray mult_done pulse while in IDLE -> exactly one done per operation; the stray pulse causes no state change.
